// File: rtl/pipe3_fwd_core_if.sv
// Fetch, writeback and debug bus of the 3-stage forwarding core.
// The core connects through the master modport and the surrounding board logic through slave.
interface pipe3_fwd_core_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int PC_W   = 12
);
  localparam int RA_W = $clog2(NREG);

  logic [15:0]       instr_i;
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [PC_W-1:0]   pc_o;
  logic              wb_valid_o;
  logic [RA_W-1:0]   wb_rd_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [RA_W-1:0]   dbg_addr_i;
  logic [DATA_W-1:0] dbg_data_o;
  logic              mult_busy_o;
  logic [15:0]       retired_o;

  modport master (
    input  instr_i, instr_valid_i, dbg_addr_i,
    output instr_ready_o, pc_o, wb_valid_o, wb_rd_o, wb_data_o,
           dbg_data_o, mult_busy_o, retired_o
  );

  modport slave (
    output instr_i, instr_valid_i, dbg_addr_i,
    input  instr_ready_o, pc_o, wb_valid_o, wb_rd_o, wb_data_o,
           dbg_data_o, mult_busy_o, retired_o
  );
endinterface

// File: rtl/pipe3_fwd_core.sv
// Decode/Execute/Memory pipeline for the 16-bit lab ISA with full forwarding,
// branch flush in E and a background multiplier that interlocks MULT/MFLO/MFHI.
module pipe3_fwd_core #(
  parameter int DATA_W      = 16,
  parameter int NREG        = 16,
  parameter int PC_W        = 12,
  parameter int MULT_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  pipe3_fwd_core_if.master bus
);
  localparam int RA_W  = $clog2(NREG);
  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLTI, OP_AND, OP_OR, OP_XOR, OP_ANDI, OP_ORI,
    OP_XORI, OP_ADDI, OP_SUBI, OP_JMP, OP_BEQZ, OP_MFLO, OP_MFHI, OP_MULT
  } opcode_e;

  typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;

  logic [PC_W-1:0]   pc;
  logic              d_valid, e_valid, m_valid, m_wen;
  logic [15:0]       d_instr, e_instr;
  logic [PC_W-1:0]   d_pc, e_pc;
  logic [DATA_W-1:0] e_a, e_b, m_data;
  logic [RA_W-1:0]   m_rd;
  logic [DATA_W-1:0] regfile [NREG];
  logic [DATA_W-1:0] hi, lo, hi_n, lo_n;
  logic [15:0]       retired;

  mul_state_e          mul_state, mul_state_n;
  logic [CNT_W-1:0]    mul_cnt, mul_cnt_n;
  logic [2*DATA_W-1:0] mul_prod, mul_prod_n;

  opcode_e           d_op, e_op;
  logic [RA_W-1:0]   d_ra, d_rb, e_rd;
  logic [DATA_W-1:0] e_imm, e_result, fwd_a, fwd_b;
  logic              e_wen, mul_busy, mul_start, taken, stall, accept;
  logic [PC_W-1:0]   target;

  assign d_op  = opcode_e'(d_instr[15:12]);
  assign d_ra  = d_instr[4 +: RA_W];
  assign d_rb  = d_instr[0 +: RA_W];
  assign e_op  = opcode_e'(e_instr[15:12]);
  assign e_rd  = e_instr[8 +: RA_W];
  assign e_imm = DATA_W'(e_instr[3:0]);

  assign mul_busy  = (mul_state == MUL_RUN);
  assign mul_start = e_valid && (e_op == OP_MULT);

  always_comb begin
    e_result = '0;
    case (e_op)
      OP_ADD:  e_result = e_a + e_b;
      OP_SUB:  e_result = e_a - e_b;
      OP_SLTI: e_result = (e_a > e_imm) ? DATA_W'(1) : '0;
      OP_AND:  e_result = e_a & e_b;
      OP_OR:   e_result = e_a | e_b;
      OP_XOR:  e_result = e_a ^ e_b;
      OP_ANDI: e_result = e_a & e_imm;
      OP_ORI:  e_result = e_a | e_imm;
      OP_XORI: e_result = e_a ^ e_imm;
      OP_ADDI: e_result = e_a + e_imm;
      OP_SUBI: e_result = e_a - e_imm;
      OP_MFLO: e_result = lo;
      OP_MFHI: e_result = hi;
      OP_JMP, OP_BEQZ, OP_MULT: e_result = '0;
    endcase
  end

  // JMP/BEQZ/MULT never write; r0 writes are dropped here so they never forward or show on wb.
  assign e_wen = e_valid && (e_rd != '0) &&
                 !(e_op inside {OP_JMP, OP_BEQZ, OP_MULT});

  // Younger producer wins: E result, then M result, then the register file.
  always_comb begin
    fwd_a = (int'(d_ra) < NREG) ? regfile[d_ra] : '0;
    fwd_b = (int'(d_rb) < NREG) ? regfile[d_rb] : '0;
    if (m_wen && (m_rd == d_ra)) fwd_a = m_data;
    if (m_wen && (m_rd == d_rb)) fwd_b = m_data;
    if (e_wen && (e_rd == d_ra)) fwd_a = e_result;
    if (e_wen && (e_rd == d_rb)) fwd_b = e_result;
  end

  assign taken  = e_valid && ((e_op == OP_JMP) || ((e_op == OP_BEQZ) && (e_a == '0)));
  assign target = (e_op == OP_JMP) ? PC_W'(e_instr[11:0])
                                   : e_pc + PC_W'(1) + PC_W'($signed(e_instr[3:0]));

  assign stall  = d_valid && (d_op inside {OP_MFLO, OP_MFHI, OP_MULT}) &&
                  (mul_busy || mul_start);
  assign accept = bus.instr_valid_i && bus.instr_ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      d_valid <= 1'b0;
      d_instr <= '0;
      d_pc    <= '0;
      e_valid <= 1'b0;
      e_instr <= '0;
      e_pc    <= '0;
      e_a     <= '0;
      e_b     <= '0;
      m_valid <= 1'b0;
      m_wen   <= 1'b0;
      m_rd    <= '0;
      m_data  <= '0;
      retired <= '0;
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else begin
      if (taken) begin
        pc      <= target;
        d_valid <= 1'b0;
      end else if (!stall) begin
        d_valid <= accept;
        if (accept) begin
          d_instr <= bus.instr_i;
          d_pc    <= pc;
          pc      <= pc + PC_W'(1);
        end
      end
      e_valid <= d_valid && !stall && !taken;
      e_instr <= d_instr;
      e_pc    <= d_pc;
      e_a     <= fwd_a;
      e_b     <= fwd_b;
      m_valid <= e_valid;
      m_wen   <= e_wen;
      m_rd    <= e_wen ? e_rd : '0;
      m_data  <= e_wen ? e_result : '0;
      if (m_valid) retired <= retired + 16'd1;
      if (m_wen) regfile[m_rd] <= m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
      mul_prod  <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      mul_state <= mul_state_n;
      mul_cnt   <= mul_cnt_n;
      mul_prod  <= mul_prod_n;
      hi        <= hi_n;
      lo        <= lo_n;
    end
  end

  // Product is captured at start; HI/LO only change on the last busy cycle.
  always_comb begin
    mul_state_n = mul_state;
    mul_cnt_n   = mul_cnt;
    mul_prod_n  = mul_prod;
    hi_n        = hi;
    lo_n        = lo;
    case (mul_state)
      MUL_IDLE: begin
        if (mul_start) begin
          mul_state_n = MUL_RUN;
          mul_cnt_n   = CNT_W'(MULT_CYCLES);
          mul_prod_n  = (2*DATA_W)'(e_a) * (2*DATA_W)'(e_b);
        end
      end
      MUL_RUN: begin
        if (mul_cnt == CNT_W'(1)) begin
          mul_state_n  = MUL_IDLE;
          {hi_n, lo_n} = mul_prod;
        end else begin
          mul_cnt_n = mul_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  assign bus.instr_ready_o = !reset && !stall;
  assign bus.pc_o          = pc;
  assign bus.wb_valid_o    = m_wen;
  assign bus.wb_rd_o       = m_rd;
  assign bus.wb_data_o     = m_data;
  assign bus.dbg_data_o    = (int'(bus.dbg_addr_i) < NREG) ? regfile[bus.dbg_addr_i] : '0;
  assign bus.mult_busy_o   = mul_busy;
  assign bus.retired_o     = retired;
endmodule

// File: tb/tb_pipe3_fwd_core.sv
// Bench for pipe3_fwd_core: programs run from a bench-side instruction RAM while
// an instruction-level model fills a writeback scoreboard and final register state.
module tb_pipe3_fwd_core;
  localparam int DATA_W      = 16;
  localparam int NREG        = 16;
  localparam int PC_W        = 12;
  localparam int MULT_CYCLES = 4;
  localparam int MAX_CYCLES  = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe3_fwd_core_if #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) bus();

  pipe3_fwd_core #(
    .DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .MULT_CYCLES(MULT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [15:0] mem [64];
  int          prog_len;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_cycles;
  bit          timed_out;
  logic [15:0] iss_reg [16];
  logic [15:0] iss_hi, iss_lo;
  int          iss_retired;

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h9000;
  endtask

  // Architectural reference: executes the program in order, one instruction at a time.
  task automatic iss_run();
    int pc = 0;
    int guard = 0;
    int nxt, off;
    logic [15:0] ins, a, b, imm, res;
    logic [3:0]  op, rd;
    bit          wr;
    while (pc < prog_len && guard < 200) begin
      ins = mem[pc];
      op  = ins[15:12];
      rd  = ins[11:8];
      a   = (ins[7:4] == 4'd0) ? 16'h0 : iss_reg[ins[7:4]];
      b   = (ins[3:0] == 4'd0) ? 16'h0 : iss_reg[ins[3:0]];
      imm = {12'h0, ins[3:0]};
      wr  = 1'b1;
      res = 16'h0;
      nxt = (pc + 1) & 'hFFF;
      case (op)
        4'h0: res = a + b;
        4'h1: res = a - b;
        4'h2: res = (a > imm) ? 16'd1 : 16'd0;
        4'h3: res = a & b;
        4'h4: res = a | b;
        4'h5: res = a ^ b;
        4'h6: res = a & imm;
        4'h7: res = a | imm;
        4'h8: res = a ^ imm;
        4'h9: res = a + imm;
        4'hA: res = a - imm;
        4'hB: begin wr = 1'b0; nxt = int'(ins[11:0]); end
        4'hC: begin
          wr  = 1'b0;
          off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
          if (a == 16'h0) nxt = (pc + 1 + off) & 'hFFF;
        end
        4'hD: res = iss_lo;
        4'hE: res = iss_hi;
        4'hF: begin wr = 1'b0; {iss_hi, iss_lo} = 32'(a) * 32'(b); end
      endcase
      if (wr && rd != 4'd0) begin
        iss_reg[rd] = res;
        exp_q.push_back({rd, res});
      end
      iss_retired++;
      pc = nxt;
      guard++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) iss_reg[i] = 16'h0;
    iss_hi = 16'h0;
    iss_lo = 16'h0;
    iss_retired = 0;
    exp_q.delete();
    obs_q.delete();
    stall_cycles = 0;
  endtask

  // One clock of the instruction RAM; writeback pulses are collected for the scoreboard.
  task automatic step(output bit acc);
    @(negedge clk);
    bus.instr_valid_i = (int'(bus.pc_o) < prog_len);
    bus.instr_i = bus.instr_valid_i ? mem[bus.pc_o[5:0]] : 16'h0;
    acc = bus.instr_valid_i && bus.instr_ready_o;
    if (bus.instr_valid_i && !bus.instr_ready_o) stall_cycles++;
    @(posedge clk);
    #1;
    if (bus.wb_valid_o) obs_q.push_back({bus.wb_rd_o, bus.wb_data_o});
  endtask

  task automatic run_program();
    int idle = 0;
    bit acc;
    timed_out = 1'b1;
    for (int c = 0; c < MAX_CYCLES; c++) begin
      step(acc);
      if (int'(bus.pc_o) >= prog_len && !bus.mult_busy_o) idle++;
      else idle = 0;
      if (idle >= 8) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.instr_i = 16'h9105;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.instr_ready_o); end
    do_reset();
    bus.dbg_addr_i = 4'd5;
    #1;
    checks++;
    if ({bus.pc_o, bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o} !== 33'h0) begin
      failures++; $display("[TB] FAIL reset_outputs: pc=%h wbv=%b rd=%h data=%h expected all 0", bus.pc_o, bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o);
    end
    checks++;
    if ({bus.mult_busy_o, bus.retired_o, bus.dbg_data_o} !== 33'h0) begin
      failures++; $display("[TB] FAIL reset_state: busy=%b retired=%0d dbg=%h expected 0", bus.mult_busy_o, bus.retired_o, bus.dbg_data_o);
    end
    checks++;
    if (bus.instr_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.instr_ready_o); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_reset();
    clear_mem();
    mem[0] = 16'h9105; mem[1] = 16'h9213; mem[2] = 16'h0312; mem[3] = 16'h1431;
    prog_len = 4;
    iss_run();
    bus.dbg_addr_i = 4'd1;
    for (int k = 0; k <= 4; k++) begin
      step(acc);
      if (k == 0) begin
        checks++;
        if (acc !== 1'b1) begin failures++; $display("[TB] FAIL first_accept: got %b expected 1", acc); end
      end
      if (k == 2) begin
        checks++;
        if (bus.dbg_data_o !== 16'd0) begin failures++; $display("[TB] FAIL r1_early: got %h expected 0000", bus.dbg_data_o); end
      end
      if (k == 3) begin
        checks++;
        if (bus.dbg_data_o !== 16'd5) begin failures++; $display("[TB] FAIL r1_at_n3: got %h expected 0005", bus.dbg_data_o); end
      end
      if (k == 4) begin
        bus.dbg_addr_i = 4'd2;
        #1;
        checks++;
        if (bus.dbg_data_o !== 16'd8) begin failures++; $display("[TB] FAIL r2_at_n4: got %h expected 0008", bus.dbg_data_o); end
      end
    end
    run_program();
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL b2b_wb_count: got %0d expected %0d timeout=%b", obs_q.size(), exp_q.size(), timed_out); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("[TB] FAIL b2b_wb%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    for (int r = 3; r <= 4; r++) begin
      bus.dbg_addr_i = 4'(r);
      #1;
      checks++;
      if (bus.dbg_data_o !== iss_reg[r]) begin failures++; $display("[TB] FAIL b2b_r%0d: got %h expected %h", r, bus.dbg_data_o, iss_reg[r]); end
    end
    checks++;
    if (bus.retired_o !== 16'(iss_retired)) begin failures++; $display("[TB] FAIL b2b_retired: got %0d expected %0d", bus.retired_o, iss_retired); end
  endtask

  // Shared shape for the program-level scenarios: run, then compare scoreboard and state.
  task automatic test_program(input string name);
    iss_run();
    run_program();
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL %s_wb_count: got %0d expected %0d timeout=%b", name, obs_q.size(), exp_q.size(), timed_out); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [19:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("[TB] FAIL %s_wb: got rd/data %h expected %h", name, o, e); end
    end
    for (int r = 0; r < NREG; r++) begin
      bus.dbg_addr_i = 4'(r);
      #1;
      checks++;
      if (bus.dbg_data_o !== iss_reg[r]) begin failures++; $display("[TB] FAIL %s_r%0d: got %h expected %h", name, r, bus.dbg_data_o, iss_reg[r]); end
    end
    checks++;
    if (bus.retired_o !== 16'(iss_retired)) begin failures++; $display("[TB] FAIL %s_retired: got %0d expected %0d", name, bus.retired_o, iss_retired); end
  endtask

  task automatic test_mem_forward();
    do_reset();
    clear_mem();
    mem[0] = 16'h9105; mem[2] = 16'h9213; mem[4] = 16'h0312; mem[6] = 16'h1431;
    prog_len = 7;
    test_program("mfwd");
    bus.dbg_addr_i = 4'd4;
    #1;
    checks++;
    if (bus.dbg_data_o !== 16'd8) begin failures++; $display("[TB] FAIL mfwd_r4_const: got %h expected 0008", bus.dbg_data_o); end
  endtask

  task automatic test_jump();
    do_reset();
    clear_mem();
    mem[0] = 16'hB020; mem[1] = 16'h9501; mem[2] = 16'h9502;
    prog_len = 32;
    test_program("jmp");
    checks++;
    if (bus.pc_o !== 12'h020) begin failures++; $display("[TB] FAIL jmp_pc: got %h expected 020", bus.pc_o); end
    checks++;
    if (bus.retired_o !== 16'd1) begin failures++; $display("[TB] FAIL jmp_retired_const: got %0d expected 1", bus.retired_o); end
  endtask

  task automatic test_branch();
    do_reset();
    clear_mem();
    mem[0] = 16'h9105; mem[4] = 16'hC002; mem[5] = 16'h9601; mem[6] = 16'h9602;
    mem[7] = 16'hC012; mem[8] = 16'h9703; mem[9] = 16'h9804;
    prog_len = 10;
    test_program("beqz");
    checks++;
    if (bus.retired_o !== 16'd8) begin failures++; $display("[TB] FAIL beqz_retired_const: got %0d expected 8", bus.retired_o); end
  endtask

  task automatic test_mult();
    do_reset();
    clear_mem();
    mem[0] = 16'h9107; mem[1] = 16'h9209; mem[2] = 16'hF012; mem[3] = 16'hD300; mem[4] = 16'hE400;
    prog_len = 5;
    test_program("mult");
    checks++;
    if (stall_cycles != MULT_CYCLES + 1) begin failures++; $display("[TB] FAIL mult_stall_cycles: got %0d expected %0d", stall_cycles, MULT_CYCLES + 1); end
    bus.dbg_addr_i = 4'd3;
    #1;
    checks++;
    if (bus.dbg_data_o !== 16'd63) begin failures++; $display("[TB] FAIL mult_r3_const: got %h expected 003f", bus.dbg_data_o); end
  endtask

  task automatic test_mult_max();
    do_reset();
    clear_mem();
    mem[0] = 16'hA101; mem[1] = 16'hA201; mem[2] = 16'hF012; mem[3] = 16'hD300; mem[4] = 16'hE400;
    prog_len = 5;
    test_program("multmax");
    bus.dbg_addr_i = 4'd4;
    #1;
    checks++;
    if (bus.dbg_data_o !== 16'hFFFE) begin failures++; $display("[TB] FAIL multmax_hi_const: got %h expected fffe", bus.dbg_data_o); end
  endtask

  task automatic test_reset_mid_mult();
    bit acc;
    do_reset();
    clear_mem();
    mem[0] = 16'hA101; mem[1] = 16'hA201; mem[2] = 16'hF012; mem[3] = 16'hD300; mem[4] = 16'hF012;
    prog_len = 5;
    for (int c = 0; c < 40 && !(obs_q.size() >= 3 && bus.mult_busy_o); c++) step(acc);
    checks++;
    if (!(obs_q.size() >= 3 && bus.mult_busy_o)) begin failures++; $display("[TB] FAIL midmult_busy: got busy=%b wbs=%0d expected busy=1 wbs=3", bus.mult_busy_o, obs_q.size()); end
    @(negedge clk);
    reset = 1'b1;
    bus.instr_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.mult_busy_o, bus.pc_o, bus.retired_o, bus.wb_valid_o} !== 30'h0) begin
      failures++; $display("[TB] FAIL midmult_reset: busy=%b pc=%h retired=%0d wbv=%b expected all 0", bus.mult_busy_o, bus.pc_o, bus.retired_o, bus.wb_valid_o);
    end
    do_reset();
    clear_mem();
    mem[0] = 16'hD300; mem[1] = 16'hE400; mem[2] = 16'h9003;
    prog_len = 3;
    test_program("postreset");
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = 16'h0;
    bus.dbg_addr_i = '0;
    prog_len = 0;
    test_reset();
    test_back_to_back();
    test_mem_forward();
    test_jump();
    test_branch();
    test_mult();
    test_mult_max();
    test_reset_mid_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
